// File: rtl/riscv_lsu_pkg.sv
// Shared load/store unit configuration: data width, funct3 encodings,
// FSM state encodings and the access-size decode.
package riscv_lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef logic [1:0] lsu_state_t;

   localparam lsu_state_t ST_IDLE = 2'd0;
   localparam lsu_state_t ST_REQ  = 2'd1;
   localparam lsu_state_t ST_RSP  = 2'd2;
   localparam lsu_state_t ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } lsu_size_e;

   // Unused funct3 codes fall through to word accesses.
   function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
      case (funct3)
         LSU_B, LSU_BU: return SZ_B;
         LSU_H, LSU_HU: return SZ_H;
         default:       return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extract/extend and misalignment detection.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic            misalign,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_rep,
   output logic [XLEN-1:0] rdata_ext
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic        sext;

   always_comb begin
      case (addr_lo)
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
      // funct3[2] marks the unsigned (BU/HU) variants.
      sext  = ~funct3[2];

      misalign  = 1'b0;
      be        = '1;
      wdata_rep = wdata;
      rdata_ext = rword;

      case (lsu_size(funct3))
         SZ_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sext & rbyte[7]}}, rbyte};
         end
         SZ_H: begin
            misalign  = addr_lo[0];
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sext & rhalf[15]}}, rhalf};
         end
         default: begin
            misalign = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: request/grant/response bus master with
// pipeline stall, response timeout and extended load data.
module riscv_lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_lsu_req_valid,
   input  logic            i_lsu_we,
   input  logic [2:0]      i_lsu_funct3,
   input  logic [XLEN-1:0] i_lsu_addr,
   input  logic [XLEN-1:0] i_lsu_wdata,
   output logic            o_lsu_stall,
   output logic [XLEN-1:0] o_lsu_rdata,
   output logic            o_lsu_misalign,
   output logic            o_lsu_bus_err,
   output logic            o_dmem_req,
   input  logic            i_dmem_gnt,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [3:0]      o_dmem_be,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata
);
   import riscv_lsu_pkg::*;

   localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   lsu_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            misalign_q, misalign_d;
   logic            bus_err_q, bus_err_d;

   logic            idle;
   logic [2:0]      al_funct3;
   logic [1:0]      al_addr_lo;
   logic            al_misalign;
   logic [3:0]      al_be;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;

   // One lane unit serves both phases: live request fields while idle
   // (misalign check, capture), captured fields afterwards (load extract).
   assign idle       = (state_q == ST_IDLE);
   assign al_funct3  = idle ? i_lsu_funct3    : funct3_q;
   assign al_addr_lo = idle ? i_lsu_addr[1:0] : addr_q[1:0];

   riscv_lsu_align u_align (
      .funct3    (al_funct3),
      .addr_lo   (al_addr_lo),
      .wdata     (i_lsu_wdata),
      .rword     (i_dmem_rdata),
      .misalign  (al_misalign),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_ext (al_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_lsu_req_valid) begin
               if (al_misalign) begin
                  misalign_d = 1'b1;
               end else begin
                  we_d     = i_lsu_we;
                  funct3_d = i_lsu_funct3;
                  addr_d   = i_lsu_addr;
                  be_d     = al_be;
                  wdata_d  = al_wdata;
                  state_d  = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (i_dmem_gnt) begin
               cnt_d   = '0;
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            cnt_d = cnt_q + 1'b1;
            // A response arriving on the timeout cycle still completes normally.
            if (i_dmem_rvalid) begin
               if (!we_q) begin
                  rdata_d = al_rdata;
               end
               state_d = ST_DONE;
            end else if (cnt_d == CNT_MAX) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign o_lsu_stall    = i_lsu_req_valid & ~al_misalign & (state_q != ST_DONE);
   assign o_lsu_rdata    = rdata_q;
   assign o_lsu_misalign = misalign_q;
   assign o_lsu_bus_err  = bus_err_q;
   assign o_dmem_req     = (state_q == ST_REQ);
   assign o_dmem_we      = we_q;
   assign o_dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
   assign o_dmem_be      = be_q;
   assign o_dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: transaction-level reference model
// with a per-cycle compare against the DUT outputs.
module tb_riscv_lsu;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_lsu_req_valid = 1'b0;
   logic        i_lsu_we = 1'b0;
   logic [2:0]  i_lsu_funct3 = '0;
   logic [31:0] i_lsu_addr = '0;
   logic [31:0] i_lsu_wdata = '0;
   logic        i_dmem_gnt = 1'b0;
   logic        i_dmem_rvalid = 1'b0;
   logic [31:0] i_dmem_rdata = '0;
   logic        o_lsu_stall;
   logic [31:0] o_lsu_rdata;
   logic        o_lsu_misalign;
   logic        o_lsu_bus_err;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;

   always #5 clk = ~clk;

   riscv_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
      .i_clk           (clk),
      .i_rstn          (i_rstn),
      .i_lsu_req_valid (i_lsu_req_valid),
      .i_lsu_we        (i_lsu_we),
      .i_lsu_funct3    (i_lsu_funct3),
      .i_lsu_addr      (i_lsu_addr),
      .i_lsu_wdata     (i_lsu_wdata),
      .o_lsu_stall     (o_lsu_stall),
      .o_lsu_rdata     (o_lsu_rdata),
      .o_lsu_misalign  (o_lsu_misalign),
      .o_lsu_bus_err   (o_lsu_bus_err),
      .o_dmem_req      (o_dmem_req),
      .i_dmem_gnt      (i_dmem_gnt),
      .o_dmem_we       (o_dmem_we),
      .o_dmem_addr     (o_dmem_addr),
      .o_dmem_be       (o_dmem_be),
      .o_dmem_wdata    (o_dmem_wdata),
      .i_dmem_rvalid   (i_dmem_rvalid),
      .i_dmem_rdata    (i_dmem_rdata)
   );

   int total = 0;
   int bad = 0;

   // expected outputs for the current cycle, set by the driver
   logic        e_on = 1'b0;
   logic        e_stall = 1'b0;
   logic        e_req = 1'b0;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = '0;
   logic [3:0]  e_be = '0;
   logic [31:0] e_wdata = '0;
   logic        e_mis = 1'b0;
   logic        e_err = 1'b0;
   logic [31:0] m_rdata = '0;

   int stall_n = 0;
   int req_n = 0;
   int mis_n = 0;
   int err_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic m_al(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) % m_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int sz;
      int lo;
      logic [3:0] r;
      sz = m_size(f3);
      lo = int'(a[1:0]) & ~(sz - 1);
      r = '0;
      for (int i = 0; i < sz; i++) r[lo + i] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
      case (m_size(f3))
         1:       return {w[7:0], w[7:0], w[7:0], w[7:0]};
         2:       return {w[15:0], w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
      int sz;
      int lo;
      logic [31:0] v;
      sz = m_size(f3);
      if (sz == 4) return w;
      lo = int'(a[1:0]) & ~(sz - 1);
      v = (w >> (8 * lo)) & ((32'd1 << (8 * sz)) - 32'd1);
      if (f3[2] == 1'b0 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      return v;
   endfunction

   // One memory-stage access. gd: REQ cycles before grant; rdl: RSP cycle
   // index carrying rvalid (negative or >= TO means no response).
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int gd, input int rdl,
                      input logic [31:0] word);
      int   nrsp;
      logic ok;
      @(posedge clk); #1;
      i_lsu_req_valid = 1'b1;
      i_lsu_we        = we;
      i_lsu_funct3    = f3;
      i_lsu_addr      = a;
      i_lsu_wdata     = wd;
      i_dmem_gnt      = 1'b0;
      i_dmem_rvalid   = 1'b0;
      i_dmem_rdata    = $urandom;
      e_req   = 1'b0;
      e_mis   = 1'b0;
      e_err   = 1'b0;
      e_stall = m_al(f3, a);
      if (!m_al(f3, a)) begin
         @(posedge clk); #1;
         i_lsu_req_valid = 1'b0;
         e_stall = 1'b0;
         e_mis   = 1'b1;
         @(posedge clk); #1;
         e_mis = 1'b0;
         return;
      end
      e_we    = we;
      e_addr  = {a[31:2], 2'b00};
      e_be    = m_be(f3, a);
      e_wdata = m_wd(f3, wd);
      for (int k = 0; k <= gd; k++) begin
         @(posedge clk); #1;
         e_req         = 1'b1;
         i_dmem_gnt    = (k == gd);
         i_dmem_rvalid = 1'($urandom_range(0, 1));
         i_dmem_rdata  = $urandom;
      end
      ok   = (rdl >= 0) && (rdl < int'(TO));
      nrsp = ok ? rdl + 1 : int'(TO);
      for (int k = 0; k < nrsp; k++) begin
         @(posedge clk); #1;
         e_req         = 1'b0;
         i_dmem_gnt    = 1'($urandom_range(0, 1));
         i_dmem_rvalid = ok && (k == rdl);
         i_dmem_rdata  = (ok && k == rdl) ? word : $urandom;
      end
      @(posedge clk); #1;
      i_dmem_gnt    = 1'b0;
      i_dmem_rvalid = 1'b0;
      e_stall       = 1'b0;
      if (!ok) begin
         m_rdata = '0;
         e_err   = 1'b1;
      end else if (!we) begin
         m_rdata = m_ext(f3, a, word);
      end
      @(posedge clk); #1;
      i_lsu_req_valid = 1'b0;
      e_err           = 1'b0;
      i_dmem_gnt      = 1'($urandom_range(0, 1));
      i_dmem_rvalid   = 1'($urandom_range(0, 1));
   endtask

   task automatic random_txns(input int n);
      logic [2:0]  f3;
      logic [31:0] a;
      int          gd;
      int          rdl;
      for (int i = 0; i < n; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (m_size(f3) == 2) a[0] = 1'b0;
            if (m_size(f3) == 4) a[1:0] = 2'b00;
         end
         gd  = $urandom_range(0, 3);
         rdl = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO);
         txn(1'($urandom_range(0, 1)), f3, a, $urandom, gd, rdl, $urandom);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   32'(o_dmem_req), 32'd0);
      chk({tag, "_we"},    32'(o_dmem_we), 32'd0);
      chk({tag, "_addr"},  o_dmem_addr, 32'd0);
      chk({tag, "_be"},    32'(o_dmem_be), 32'd0);
      chk({tag, "_wdata"}, o_dmem_wdata, 32'd0);
      chk({tag, "_rdata"}, o_lsu_rdata, 32'd0);
      chk({tag, "_mis"},   32'(o_lsu_misalign), 32'd0);
      chk({tag, "_err"},   32'(o_lsu_bus_err), 32'd0);
      chk({tag, "_stall"}, 32'(o_lsu_stall), 32'd0);
   endtask

   initial begin
      fork
         begin : compare
            forever begin
               @(negedge clk);
               if (e_on) begin
                  chk("stall", 32'(o_lsu_stall), 32'(e_stall));
                  chk("dmem_req", 32'(o_dmem_req), 32'(e_req));
                  if (e_req) begin
                     chk("dmem_we", 32'(o_dmem_we), 32'(e_we));
                     chk("dmem_addr", o_dmem_addr, e_addr);
                     chk("dmem_be", 32'(o_dmem_be), 32'(e_be));
                     chk("dmem_wdata", o_dmem_wdata, e_wdata);
                  end
                  chk("misalign", 32'(o_lsu_misalign), 32'(e_mis));
                  chk("bus_err", 32'(o_lsu_bus_err), 32'(e_err));
                  chk("rdata", o_lsu_rdata, m_rdata);
                  if (o_lsu_stall)    stall_n++;
                  if (o_dmem_req)     req_n++;
                  if (o_lsu_misalign) mis_n++;
                  if (o_lsu_bus_err)  err_n++;
               end
            end
         end
         begin : driver
            int s0, r0, m0, b0;
            repeat (2) @(posedge clk);
            #1;
            chk_all_zero("reset");
            i_rstn = 1'b1;
            e_on   = 1'b1;

            chk("model_be_b3", 32'(m_be(3'b000, 32'h103)), 32'h8);
            chk("model_be_h2", 32'(m_be(3'b001, 32'h102)), 32'hC);
            chk("model_wd_h", m_wd(3'b001, 32'h1234ABCD), 32'hABCDABCD);

            s0 = stall_n;
            txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
            chk("lw_rdata", o_lsu_rdata, 32'hDEADBEEF);
            chk("lw_stall_cycles", 32'(stall_n - s0), 32'd3);

            txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
            chk("lb_rdata", o_lsu_rdata, 32'hFFFFFF80);
            txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 2, 32'h80FF0000);
            chk("lbu_rdata", o_lsu_rdata, 32'h00000080);

            r0 = req_n;
            txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 4, 0, 32'h0);
            chk("sh_req_cycles", 32'(req_n - r0), 32'd5);
            chk("sh_keeps_rdata", o_lsu_rdata, 32'h00000080);

            r0 = req_n; m0 = mis_n; s0 = stall_n;
            txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
            txn(1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
            chk("mis_pulses", 32'(mis_n - m0), 32'd2);
            chk("mis_no_req", 32'(req_n - r0), 32'd0);
            chk("mis_no_stall", 32'(stall_n - s0), 32'd0);

            b0 = err_n; s0 = stall_n;
            txn(1'b0, 3'b010, 32'h300, 32'h0, 0, -1, 32'h0);
            chk("timeout_rdata", o_lsu_rdata, 32'h0);
            chk("timeout_err_pulses", 32'(err_n - b0), 32'd1);
            chk("timeout_stall_cycles", 32'(stall_n - s0), 32'(2 + TO));

            b0 = err_n;
            txn(1'b0, 3'b010, 32'h304, 32'h0, 0, int'(TO) - 1, 32'hCAFEF00D);
            chk("late_rvalid_rdata", o_lsu_rdata, 32'hCAFEF00D);
            chk("late_rvalid_no_err", 32'(err_n - b0), 32'd0);

            random_txns(150);

            // reset in the middle of a response wait
            txn(1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h5A5A1234);
            @(posedge clk); #1;
            i_lsu_req_valid = 1'b1; i_lsu_we = 1'b0;
            i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h200;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
            e_stall = 1'b1; e_req = 1'b0;
            @(posedge clk); #1;
            i_dmem_gnt = 1'b1;
            e_req = 1'b1; e_we = 1'b0; e_addr = 32'h200; e_be = 4'hF; e_wdata = i_lsu_wdata;
            @(posedge clk); #1;
            i_dmem_gnt = 1'b0; e_req = 1'b0;
            @(posedge clk); #3;
            e_on = 1'b0;
            i_rstn = 1'b0;
            i_lsu_req_valid = 1'b0;
            #1;
            chk_all_zero("midreset");
            @(posedge clk); #1;
            i_rstn = 1'b1;
            m_rdata = '0; e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_err = 1'b0;
            i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h12345678;
            e_on = 1'b1;
            @(posedge clk); #1;
            i_dmem_rvalid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("post_reset_rdata", o_lsu_rdata, 32'h0);

            random_txns(20);
            @(posedge clk); #1;
            e_on = 1'b0;
         end
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit for the pipelined RV32I core. It sits in the memory stage and is the producer of the load data that writeback selects against the ALU result.
- Accepts one load or store per memory-stage instruction.
- Drives a request/grant/response data-memory bus.
- Generates byte enables and store-data lane replication.
- Returns sign/zero-extended load data.
- Holds the pipeline (stall) until the access completes.

Parameters:
XLEN, 32, data/address width (from the common config, fixed 32 for RV32I)
TIMEOUT, 255, max cycles waiting for i_dmem_rvalid before bus error (counter width = $clog2(TIMEOUT+1))

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_lsu_req_valid  in  1  memory-stage instruction is a load/store
i_lsu_we  in  1  1 = store, 0 = load
i_lsu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
i_lsu_addr  in  XLEN  effective byte address
i_lsu_wdata  in  XLEN  store data (rs2)
o_lsu_stall  out  1  hold IF/ID/EX/MEM pipeline registers
o_lsu_rdata  out  XLEN  extended load data to writeback
o_lsu_misalign  out  1  misaligned-access pulse
o_lsu_bus_err  out  1  timeout pulse
o_dmem_req  out  1  bus request
i_dmem_gnt  in  1  bus accepts request this cycle
o_dmem_we  out  1  write enable
o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_rvalid  in  1  response (read data or write ack)
i_dmem_rdata  in  XLEN  read word

Behaviour:
Reset (i_rstn low, asynchronous):
- state = IDLE.
- All o_dmem_* = 0; o_lsu_rdata = 0; o_lsu_misalign = 0; o_lsu_bus_err = 0; timeout counter = 0.

States:
- IDLE:
  - i_lsu_req_valid & aligned → capture we/funct3/addr/wdata; go to REQ.
  - i_lsu_req_valid & misaligned → stay in IDLE; o_lsu_misalign = 1 for one cycle; no bus activity.
- REQ:
  - o_dmem_req = 1, o_dmem_* driven from captured values.
  - i_dmem_gnt = 1 → go to RSP, clear counter. Request must be held stable until granted.
- RSP:
  - o_dmem_req = 0; counter increments each cycle.
  - i_dmem_rvalid → register extended load data into o_lsu_rdata (stores leave it unchanged); go to DONE.
  - Counter == TIMEOUT without rvalid → o_lsu_rdata = 0, o_lsu_bus_err = 1 for one cycle; go to DONE.
  - rvalid and timeout in the same cycle → rvalid wins.
- DONE: stall released for exactly one cycle so the pipeline advances; go to IDLE. A new request is not accepted in DONE.

Stall:
- o_lsu_stall = i_lsu_req_valid & aligned & (state != DONE). It is combinational from i_lsu_req_valid.
- Aligned load latency with gnt and rvalid each 1 cycle: IDLE→REQ→RSP→DONE, 3 stall cycles; result valid in DONE.

Alignment: H/HU requires addr[0] = 0; W requires addr[1:0] = 0; B/BU are always aligned. Illegal funct3 values (011, 110, 111) are treated as W.

Byte enables:
- B: 4'b0001 << addr[1:0].
- H: addr[1] ? 4'b1100 : 4'b0011.
- W: 4'b1111.

Write data: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.

Load extract: select the byte/half lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend.

Other rules:
- A spurious i_dmem_rvalid in IDLE or REQ is ignored.
- i_dmem_gnt outside REQ is ignored.
- Reset mid-transaction returns to IDLE immediately; the outstanding response is dropped.

Decomposition:
- Shared package (the common config include):
  - funct3 load/store encodings (LSU_B/H/W/BU/HU).
  - State encodings (IDLE=0, REQ=1, RSP=2, DONE=3).
  - XLEN.
- One sub-module: riscv_lsu_align. It is combinational and generates byte enables, store-data replication, the load extract/extend, and the misalign flag. The FSM, counter and capture registers stay in the top module.

Test Plan:
1. Aligned LW: addr 0x100, gnt on the first REQ cycle, rvalid 1 cycle later, rdata 0xDEADBEEF → o_dmem_addr = 0x100, be = 1111; o_lsu_rdata = 0xDEADBEEF in DONE; stall high for exactly 3 cycles.
2. LB/LBU: addr 0x103, rdata 0x80FF_0000 → be = 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
3. SH: addr 0x102, wdata 0x1234ABCD, gnt delayed 4 cycles → o_dmem_req held 5 cycles with addr/be/wdata stable at 0x100 / 1100 / 0xABCDABCD; o_dmem_we = 1.
4. Misaligned: LW at 0x101 and LH at 0x103 → o_lsu_misalign pulses 1 cycle each; o_dmem_req stays 0; o_lsu_stall = 0.
5. Timeout: TIMEOUT = 8, rvalid never arrives → o_lsu_bus_err pulses after 8 RSP cycles; o_lsu_rdata = 0; FSM returns to IDLE via DONE.
6. Reset: assert i_rstn low during RSP → state IDLE and all outputs 0 asynchronously; a late rvalid after reset release is ignored.
